// File: rtl/memory_responder_pkg.sv
// memory_responder_pkg: shared types for the memory responder.
package memory_responder_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE, DACC, IACC, HIT} resp_state_t;
endpackage

// File: rtl/memory_responder_watchdog.sv
// memory_responder_watchdog: counts wait cycles of a RAM access and flags expiry at TIMEOUT.
module memory_responder_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic expired_o
);
  logic [31:0] cnt_q, cnt_d;
  assign cnt_d = en_i ? cnt_q + 32'd1 : '0;
  assign expired_o = en_i && cnt_q == TIMEOUT - 1;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/memory_responder.sv
// memory_responder: serialises instruction/data requests onto one RAM port, data first.
// Optional ramready watchdog enabled by defining RESP_TIMEOUT_EN.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  iREN,
  input  logic  dREN,
  input  logic  dWEN,
  input  word_t iaddr,
  input  word_t daddr,
  input  word_t dstore,
  output logic  ihit,
  output logic  dhit,
  output word_t iload,
  output word_t dload,
  output logic  ramREN,
  output logic  ramWEN,
  output word_t ramaddr,
  output word_t ramstore,
  input  word_t ramload,
  input  logic  ramready,
  output logic  err
);
  resp_state_t state_q, state_d;
  word_t addr_q, addr_d, store_q, store_d, iload_q, iload_d, dload_q, dload_d, ld;
  logic wr_q, wr_d, isd_q, isd_d, err_q, err_d, acc, expired, dreq;
  assign acc = state_q == DACC || state_q == IACC;
  assign dreq = dREN | dWEN;
`ifdef RESP_TIMEOUT_EN
  memory_responder_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(CLK), .rst(RST), .en_i(acc), .expired_o(expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign expired = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    store_d = store_q;
    wr_d    = wr_q;
    isd_d   = isd_q;
    iload_d = iload_q;
    dload_d = dload_q;
    err_d   = err_q;
    ld      = ramready ? ramload : '0;
    if (state_q == IDLE) begin
      state_d = dreq ? DACC : iREN ? IACC : IDLE;
      isd_d   = dreq;
      wr_d    = dWEN;
      addr_d  = dreq ? daddr : iREN ? iaddr : addr_q;
      store_d = dreq ? dstore : store_q;
    end else if (acc && (ramready || expired)) begin
      state_d = HIT;
      dload_d = (isd_q && !wr_q) ? ld : dload_q;
      iload_d = isd_q ? iload_q : ld;
      err_d   = err_q | (expired & ~ramready);
    end else if (state_q == HIT) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      wr_q    <= 1'b0;
      isd_q   <= 1'b0;
      iload_q <= '0;
      dload_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      wr_q    <= wr_d;
      isd_q   <= isd_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
      err_q   <= err_d;
    end
  end
  assign ramREN   = state_q == IACC || (state_q == DACC && !wr_q);
  assign ramWEN   = state_q == DACC && wr_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign ihit     = state_q == HIT && !isd_q;
  assign dhit     = state_q == HIT && isd_q;
  assign iload    = iload_q;
  assign dload    = dload_q;
  assign err      = err_q;
endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: directed checks of the memory responder.
module tb_memory_responder;
  logic CLK = 1'b0, RST, iREN, dREN, dWEN, ramready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic ihit, dhit, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;
  int checks = 0, failures = 0;
  memory_responder #(.TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .err(err)
  );
  always #5 CLK = ~CLK;
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_ihit"}, {31'd0, ihit}, 0);
    chk({tag, "_dhit"}, {31'd0, dhit}, 0);
    chk({tag, "_ren"}, {31'd0, ramREN}, 0);
    chk({tag, "_wen"}, {31'd0, ramWEN}, 0);
    chk({tag, "_addr"}, ramaddr, 0);
    chk({tag, "_store"}, ramstore, 0);
    chk({tag, "_iload"}, iload, 0);
    chk({tag, "_dload"}, dload, 0);
    chk({tag, "_err"}, {31'd0, err}, 0);
  endtask
  initial begin
    RST = 1; iREN = 0; dREN = 0; dWEN = 0; ramready = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
    step(); step();
    chk_all_zero("reset");
    RST = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_ren", {31'd0, ramREN}, 0);
      chk("idle_wen", {31'd0, ramWEN}, 0);
    end
    // instruction fetch with ramready on the third strobe cycle
    iREN = 1; iaddr = 32'h40;
    step();
    iaddr = 32'h99;
    for (int i = 0; i < 3; i++) begin
      chk("if_ren", {31'd0, ramREN}, 1);
      chk("if_addr", ramaddr, 32'h40);
      chk("if_ihit_early", {31'd0, ihit}, 0);
      if (i == 2) begin ramready = 1; ramload = 32'h8C220004; end
      step();
    end
    chk("if_ihit", {31'd0, ihit}, 1);
    chk("if_dhit", {31'd0, dhit}, 0);
    chk("if_iload", iload, 32'h8C220004);
    chk("if_ren_off", {31'd0, ramREN}, 0);
    iREN = 0; ramready = 0;
    step();
    chk("if_ihit_pulse", {31'd0, ihit}, 0);
    chk("if_iload_hold", iload, 32'h8C220004);
    // stray ramready in IDLE must be ignored
    ramready = 1; ramload = 32'hFFFFFFFF;
    step();
    ramready = 0;
    step();
    chk("stray_ihit", {31'd0, ihit}, 0);
    chk("stray_dhit", {31'd0, dhit}, 0);
    chk("stray_ren", {31'd0, ramREN}, 0);
    chk("stray_iload", iload, 32'h8C220004);
    // simultaneous instruction and data read: data first
    iREN = 1; dREN = 1; iaddr = 32'h44; daddr = 32'h200;
    step();
    chk("cf_d_ren", {31'd0, ramREN}, 1);
    chk("cf_d_wen", {31'd0, ramWEN}, 0);
    chk("cf_d_addr", ramaddr, 32'h200);
    ramready = 1; ramload = 32'h11112222;
    step();
    chk("cf_dhit", {31'd0, dhit}, 1);
    chk("cf_ihit_none", {31'd0, ihit}, 0);
    chk("cf_dload", dload, 32'h11112222);
    chk("cf_ren_gap", {31'd0, ramREN}, 0);
    dREN = 0; ramready = 0;
    step();
    chk("cf_idle_ren", {31'd0, ramREN}, 0);
    chk("cf_idle_hits", {30'd0, ihit, dhit}, 0);
    step();
    chk("cf_i_ren", {31'd0, ramREN}, 1);
    chk("cf_i_addr", ramaddr, 32'h44);
    ramready = 1; ramload = 32'h33334444;
    step();
    chk("cf_ihit", {31'd0, ihit}, 1);
    chk("cf_dhit_none", {31'd0, dhit}, 0);
    chk("cf_iload", iload, 32'h33334444);
    chk("cf_dload_keep", dload, 32'h11112222);
    iREN = 0; ramready = 0;
    step();
    // data write leaves dload untouched
    dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    step();
    chk("wr_wen", {31'd0, ramWEN}, 1);
    chk("wr_ren", {31'd0, ramREN}, 0);
    chk("wr_addr", ramaddr, 32'h100);
    chk("wr_store", ramstore, 32'hDEADBEEF);
    ramready = 1; ramload = 32'h55555555;
    step();
    chk("wr_dhit", {31'd0, dhit}, 1);
    chk("wr_ihit", {31'd0, ihit}, 0);
    chk("wr_dload", dload, 32'h11112222);
    chk("wr_wen_off", {31'd0, ramWEN}, 0);
    dWEN = 0; ramready = 0;
    step();
    chk("wr_dhit_pulse", {31'd0, dhit}, 0);
    // dREN and dWEN together behave as a write; then reset mid-access
    dREN = 1; dWEN = 1; daddr = 32'h300; dstore = 32'h5;
    step();
    chk("both_wen", {31'd0, ramWEN}, 1);
    chk("both_ren", {31'd0, ramREN}, 0);
    chk("both_addr", ramaddr, 32'h300);
    step();
    RST = 1;
    step();
    chk_all_zero("midrst");
    RST = 0; dREN = 0; dWEN = 0;
    step();
    chk("midrst_dhit", {31'd0, dhit}, 0);
    chk("midrst_wen", {31'd0, ramWEN}, 0);
    step();
    chk("midrst_dhit2", {31'd0, dhit}, 0);
`ifdef RESP_TIMEOUT_EN
    dREN = 1; daddr = 32'h500;
    step();
    dREN = 0;
    for (int i = 0; i < 4; i++) begin
      chk("to_ren", {31'd0, ramREN}, 1);
      chk("to_dhit_early", {31'd0, dhit}, 0);
      step();
    end
    chk("to_dhit", {31'd0, dhit}, 1);
    chk("to_dload", dload, 0);
    chk("to_err", {31'd0, err}, 1);
    step(); step();
    chk("to_err_sticky", {31'd0, err}, 1);
    RST = 1;
    step();
    RST = 0;
    chk("to_err_clr", {31'd0, err}, 0);
`else
    chk("err_tied", {31'd0, err}, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
